// File: rtl/lsu_mem_ctrl.sv
// LSU-side memory access controller: one request at a time, word-aligned bus
// transaction with byte strobes, right-aligned load data, misalign/timeout errors.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_lsu_i,
    output logic                  req_ready_lsu_o,
    input  logic [ADDR_WIDTH-1:0] addr_lsu_i,
    input  logic [DATA_WIDTH-1:0] st_dat_lsu_i,
    input  logic [1:0]            ls_wdth_lsu_i,
    input  logic                  ls_lsu_i,
    output logic                  resp_valid_lsu_o,
    output logic [DATA_WIDTH-1:0] rd_dat_lsu_o,
    output logic                  err_lsu_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      off;
    logic            is_load;
    logic            misal;
    logic            limit;
    logic [3:0]      strb_c;
    logic [DATA_WIDTH-1:0] wdata_c;

    always_comb begin
        misal   = 1'b0;
        strb_c  = 4'b1111;
        wdata_c = st_dat_lsu_i;
        case (ls_wdth_lsu_i)
            2'b00: begin
                strb_c  = 4'b0001 << addr_lsu_i[1:0];
                wdata_c = {4{st_dat_lsu_i[7:0]}};
            end
            2'b01: begin
                misal   = addr_lsu_i[0];
                strb_c  = 4'b0011 << addr_lsu_i[1:0];
                wdata_c = {2{st_dat_lsu_i[15:0]}};
            end
            2'b10:   misal = (addr_lsu_i[1:0] != 2'b00);
            default: misal = 1'b1;
        endcase
    end

    // cnt counts REQ/WAIT cycles already elapsed, so this cycle is the
    // (TIMEOUT_CYC-1)th one when cnt == TIMEOUT_CYC-2.
    assign limit = (cnt == CW'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            off              <= 2'b00;
            is_load          <= 1'b0;
            req_ready_lsu_o  <= 1'b1;
            resp_valid_lsu_o <= 1'b0;
            rd_dat_lsu_o     <= '0;
            err_lsu_o        <= 1'b0;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            mem_wstrb_o      <= 4'b0000;
        end else begin
            resp_valid_lsu_o <= 1'b0;
            case (state)
                IDLE: if (req_valid_lsu_i) begin
                    off             <= addr_lsu_i[1:0];
                    is_load         <= ~ls_lsu_i;
                    cnt             <= '0;
                    req_ready_lsu_o <= 1'b0;
                    if (misal) begin
                        state            <= RESP;
                        resp_valid_lsu_o <= 1'b1;
                        err_lsu_o        <= 1'b1;
                    end else begin
                        state       <= REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_lsu_i;
                        mem_addr_o  <= {addr_lsu_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_o <= wdata_c;
                        mem_wstrb_o <= ls_lsu_i ? strb_c : 4'b0000;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= WAIT;
                    end else if (limit) begin
                        mem_req_o        <= 1'b0;
                        state            <= RESP;
                        resp_valid_lsu_o <= 1'b1;
                        err_lsu_o        <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid_i) begin
                        state            <= RESP;
                        resp_valid_lsu_o <= 1'b1;
                        err_lsu_o        <= 1'b0;
                        if (is_load) rd_dat_lsu_o <= mem_rdata_i >> {off, 3'b000};
                    end else if (limit) begin
                        state            <= RESP;
                        resp_valid_lsu_o <= 1'b1;
                        err_lsu_o        <= 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    req_ready_lsu_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scenario tasks drive requests and a bus responder; responses are checked
// against an expected-response queue filled when each request is issued.
module tb_lsu_mem_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] st_dat = '0;
    logic [1:0]    wdth = 2'b00;
    logic          ls = 1'b0;
    logic          resp_valid;
    logic [DW-1:0] rd_dat;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rd;
    } resp_t;

    resp_t         exp_q[$];
    resp_t         mon_e;
    logic [DW-1:0] last_rd = '0;

    lsu_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_lsu_i(req_valid), .req_ready_lsu_o(req_ready),
        .addr_lsu_i(addr), .st_dat_lsu_i(st_dat), .ls_wdth_lsu_i(wdth), .ls_lsu_i(ls),
        .resp_valid_lsu_o(resp_valid), .rd_dat_lsu_o(rd_dat), .err_lsu_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Response monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL resp_unexpected: got resp_valid=1 err=%0b rd=%h, required no response", err, rd_dat);
            end else begin
                mon_e = exp_q.pop_front();
                if (err !== mon_e.err || rd_dat !== mon_e.rd) begin
                    mismatched++;
                    $display("FAIL resp_data: got err=%0b rd=%h, required err=%0b rd=%h", err, rd_dat, mon_e.err, mon_e.rd);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] st, input logic [1:0] w,
                          input logic l, input int gd, input int rd_d, input logic [31:0] rdata,
                          input logic bad, input logic [31:0] x_addr, input logic [3:0] x_strb,
                          input logic [31:0] x_wd, input string nm);
        resp_t e;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready: got %b, required 1", nm, req_ready);
        end
        req_valid = 1'b1; addr = a; st_dat = st; wdth = w; ls = l;
        e.err = bad;
        e.rd  = (!bad && !l) ? (rdata >> (8 * a[1:0])) : last_rd;
        last_rd = e.rd;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (bad) begin
            compared++;
            if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
                mismatched++;
                $display("FAIL %s err_latency: got resp_valid=%b mem_req=%b, required 1/0", nm, resp_valid, mem_req);
            end
            @(negedge clk);
            compared++;
            if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL %s err_after: got mem_req=%b resp_valid=%b ready=%b, required 0/0/1", nm, mem_req, resp_valid, req_ready);
            end
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            compared++;
            if (mem_req !== 1'b1 || mem_addr !== x_addr || mem_we !== l || mem_wstrb !== x_strb ||
                (l && mem_wdata !== x_wd)) begin
                mismatched++;
                $display("FAIL %s bus_req: got req=%b addr=%h we=%b strb=%b wd=%h, required 1 %h %b %b %h",
                         nm, mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata, x_addr, l, x_strb, x_wd);
            end
            if (i == gd) mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        for (int i = 0; i <= rd_d; i++) begin
            compared++;
            if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL %s wait: got mem_req=%b resp_valid=%b, required 0/0", nm, mem_req, resp_valid);
            end
            if (i == rd_d) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        compared++;
        if (resp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s resp_latency: got resp_valid=%b, required 1", nm, resp_valid);
        end
        @(negedge clk);
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s resp_end: got resp_valid=%b ready=%b, required 0/1", nm, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || err !== 1'b0 ||
            rd_dat !== 32'h0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0 || mem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: got ready=%b req=%b rv=%b err=%b rd=%h we=%b strb=%b addr=%h, required 1 0 0 0 0 0 0 0",
                     req_ready, mem_req, resp_valid, err, rd_dat, mem_we, mem_wstrb, mem_addr);
        end
        rst = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_aligned();
        do_req(32'h8000_0010, 32'h0, 2'b10, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0, 32'h8000_0010, 4'b0000, 32'h0, "word_load");
        do_req(32'h8000_0013, 32'h0000_00A5, 2'b00, 1'b1, 0, 0, 32'h0, 1'b0, 32'h8000_0010, 4'b1000, 32'hA5A5_A5A5, "byte_store");
        do_req(32'h0000_0206, 32'h1234_BEEF, 2'b01, 1'b1, 1, 1, 32'h0, 1'b0, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, "half_store");
        do_req(32'h0000_0102, 32'h0, 2'b01, 1'b0, 0, 0, 32'h1234_5678, 1'b0, 32'h0000_0100, 4'b0000, 32'h0, "half_load");
        do_req(32'h0000_0101, 32'h0, 2'b00, 1'b0, 0, 0, 32'h1234_5678, 1'b0, 32'h0000_0100, 4'b0000, 32'h0, "byte_load");
    endtask

    task automatic test_misaligned();
        do_req(32'h0000_0103, 32'h0, 2'b01, 1'b0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, "half_mis");
        do_req(32'h0000_0102, 32'h0, 2'b10, 1'b1, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, "word_mis");
        do_req(32'h0000_0100, 32'h0, 2'b11, 1'b0, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, "width_rsvd");
    endtask

    task automatic test_timeout();
        resp_t e;
        int    n;
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h0000_0200; wdth = 2'b10; ls = 1'b0;
        e.err = 1'b1; e.rd = last_rd;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        compared++;
        if (n != TO - 1) begin
            mismatched++;
            $display("FAIL timeout_req_cycles: got %0d, required %0d", n, TO - 1);
        end
        compared++;
        if (resp_valid !== 1'b1 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_resp: got resp_valid=%b err=%b, required 1/1", resp_valid, err);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || rd_dat !== last_rd) begin
            mismatched++;
            $display("FAIL stray_rvalid: got rv=%b ready=%b rd=%h, required 0/1/%h", resp_valid, req_ready, rd_dat, last_rd);
        end
        do_req(32'h0000_0204, 32'h0, 2'b10, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_0204, 4'b0000, 32'h0, "after_timeout");
    endtask

    task automatic test_reset_mid();
        do_req(32'h0000_0302, 32'h0, 2'b01, 1'b0, 3, 2, 32'hAABB_CCDD, 1'b0, 32'h0000_0300, 4'b0000, 32'h0, "slow_bus");
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h0000_0400; wdth = 2'b10; ls = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        compared++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_async: got req=%b rv=%b ready=%b, required 0/0/1", mem_req, resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            compared++;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1 || rd_dat !== 32'h0) begin
                mismatched++;
                $display("FAIL rst_after: got rv=%b req=%b ready=%b rd=%h, required 0/0/1/0", resp_valid, mem_req, req_ready, rd_dat);
            end
        end
        do_req(32'h0000_0500, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0000_0500, 4'b0000, 32'h0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_resp: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
